// File: rtl/serial_subtractor_4_bit_pkg.sv
// ============================================================================
// Module      : serial_subtractor_4_bit_pkg
// Description : Shared arithmetic types for the serial adder/subtractor family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_4_bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_4_bit_full_subtractor.sv
// ============================================================================
// Module      : serial_subtractor_4_bit_full_subtractor
// Description : Single-bit full subtractor cell, x - y - bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_4_bit_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (bin & ~(x ^ y));

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_4_bit.sv
// ============================================================================
// Module      : serial_subtractor_4_bit
// Description : Bit-serial subtractor, diff = a - b - borrowin, LSB first,
//               with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_4_bit
    import serial_subtractor_4_bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrowout
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    arith_state_t     r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_borrowout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bout;

    // One cell, reused every RUN cycle on the current LSBs and the carried borrow.
    serial_subtractor_4_bit_full_subtractor u_cell (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_borrowout <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_borrow   <= borrowin;
                        r_cnt      <= '0;
                        r_diff     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 last.
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_CNT) begin
                        r_borrowout <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrowout = r_borrowout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_4_bit.sv
// ============================================================================
// Module      : tb_serial_subtractor_4_bit
// Description : Self-checking bench with a behavioural model of the subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor_4_bit;

    localparam int W    = 4;
    localparam int LAT  = W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrowin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrowout;

    int checks = 0;
    int errors = 0;

    serial_subtractor_4_bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrowin  (borrowin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrowout (borrowout)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: remaining latency, result-holding flag, result.
    // ------------------------------------------------------------------
    int           m_left = 0;
    bit           m_hold = 1'b0;
    int           m_diff = 0;
    int           m_bout = 0;
    int           p_diff = 0;
    int           p_bout = 0;
    int           p_a = 0;
    int           p_b = 0;
    int           p_bin = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_hold = 1'b0;
            m_diff = 0;
            m_bout = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hold = 1'b1;
                m_diff = p_diff;
                m_bout = p_bout;
            end
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            p_a    = int'(a);
            p_b    = int'(b);
            p_bin  = int'(borrowin);
            p_diff = (p_a - p_b - p_bin) & ((1 << W) - 1);
            p_bout = (p_a < p_b + p_bin) ? 1 : 0;
            m_left = LAT;
        end
        #1;
        check("model_in_ready", int'(in_ready), (m_left == 0 && !m_hold) ? 1 : 0);
        check("model_out_valid", int'(out_valid), m_hold ? 1 : 0);
        if (m_left == 0) begin
            check("model_diff", int'(diff), m_diff);
            check("model_borrowout", int'(borrowout), m_bout);
        end
        if (m_hold && out_valid)
            check("invariant", int'(diff) + p_b + p_bin, p_a + int'(borrowout) * (1 << W));
    end

    // ------------------------------------------------------------------
    // Driver tasks: inputs change on the falling edge.
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", 0, 1);
    endtask

    // Issue one transaction; returns cycles from accept to out_valid.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, output int lat);
        wait_idle();
        a        = ta;
        b        = tb_;
        borrowin = tbin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        borrowin = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("done_timeout", 0, 1);
    endtask

    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tbin, input int ed, input int eb);
        int lat;
        out_ready = 1'b1;
        issue(ta, tb_, tbin, lat);
        check("lit_latency", lat, LAT);
        check("lit_diff", int'(diff), ed);
        check("lit_borrowout", int'(borrowout), eb);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        borrowin  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_borrowout", int'(borrowout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        directed(4'd9, 4'd3, 1'b0, 6, 0);
        directed(4'd3, 4'd9, 1'b0, 10, 1);
        directed(4'd0, 4'd0, 1'b1, 15, 1);
        directed(4'd15, 4'd15, 1'b0, 0, 0);

        // Backpressure with ignored in_valid pulses.
        out_ready = 1'b0;
        issue(4'd12, 4'd5, 1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a        = 4'd1;
            b        = 4'd2;
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_diff", int'(diff), 7);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_hold_diff", int'(diff), 7);

        // Reset mid-RUN.
        a        = 4'd13;
        b        = 4'd4;
        borrowin = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_run_out_valid", int'(out_valid), 0);
        check("rst_run_in_ready", int'(in_ready), 1);
        check("rst_run_diff", int'(diff), 0);
        check("rst_run_borrowout", int'(borrowout), 0);
        directed(4'd7, 4'd2, 1'b0, 5, 0);

        // Exhaustive sweep, back-to-back.
        out_ready = 1'b1;
        for (int k = 0; k < 512; k++) begin
            issue(W'(k >> 5), W'(k >> 1), k[0], lat);
        end

        // Random operands with random out_ready backpressure and idle gaps.
        for (int k = 0; k < 150; k++) begin
            out_ready = 1'($urandom);
            issue(W'($urandom), W'($urandom), 1'($urandom), lat);
            for (int n = 0; n < 30 && !in_ready; n++) begin
                out_ready = 1'($urandom);
                @(negedge clk);
            end
            out_ready = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
